// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU function codes, MIPS opcode/funct constants and
// the decoded-issue record carried from decode into the issue register.
package alu_pkg;

  // ALU function codes
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type funct field
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2a;
  localparam logic [5:0] FN_SLTU   = 6'h2b;

  typedef struct packed {
    logic [5:0]  alufun;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: turns an instruction plus forwarded operands into
// ALU operands, function code, signedness and writeback target.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [5:0]  o_alufun,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_sign,
  output logic [4:0]  o_wr_reg,
  output logic        o_wr_en,
  output logic        o_illegal
);

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  assign w_op    = i_instr[31:26];
  assign w_rt    = i_instr[20:16];
  assign w_rd    = i_instr[15:11];
  assign w_shamt = i_instr[10:6];
  assign w_funct = i_instr[5:0];
  assign w_imm   = i_instr[15:0];

  logic [5:0]  w_alufun;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_sign;
  logic [4:0]  w_wr_reg;
  logic        w_wr_en;
  logic        w_illegal;

  always_comb begin
    w_alufun  = ALU_ADD;
    w_a       = 32'd0;
    w_b       = 32'd0;
    w_sign    = 1'b0;
    w_wr_reg  = 5'd0;
    w_wr_en   = 1'b0;
    w_illegal = 1'b0;

    case (w_op)
      OP_RTYPE: begin
        w_a      = i_rs_val;
        w_b      = i_rt_val;
        w_wr_reg = w_rd;
        w_wr_en  = 1'b1;
        case (w_funct)
          FN_ADD:  begin w_alufun = ALU_ADD; w_sign = 1'b1; end
          FN_ADDU: w_alufun = ALU_ADD;
          FN_SUB:  begin w_alufun = ALU_SUB; w_sign = 1'b1; end
          FN_SUBU: w_alufun = ALU_SUB;
          FN_AND:  w_alufun = ALU_AND;
          FN_OR:   w_alufun = ALU_OR;
          FN_XOR:  w_alufun = ALU_XOR;
          FN_NOR:  w_alufun = ALU_NOR;
          FN_SLT:  begin w_alufun = ALU_LT; w_sign = 1'b1; end
          FN_SLTU: w_alufun = ALU_LT;
          // Immediate shifts carry the shift amount in operand A.
          FN_SLL:  begin w_alufun = ALU_SLL; w_a = {27'd0, w_shamt}; end
          FN_SRL:  begin w_alufun = ALU_SRL; w_a = {27'd0, w_shamt}; end
          FN_SRA:  begin w_alufun = ALU_SRA; w_a = {27'd0, w_shamt}; end
          FN_SLLV: w_alufun = ALU_SLL;
          FN_SRLV: w_alufun = ALU_SRL;
          FN_SRAV: w_alufun = ALU_SRA;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_a      = i_rs_val;
        w_b      = sext16(w_imm);
        w_wr_reg = w_rt;
        w_wr_en  = 1'b1;
        w_alufun = (w_op == OP_ADDI || w_op == OP_ADDIU) ? ALU_ADD : ALU_LT;
        w_sign   = (w_op == OP_ADDI || w_op == OP_SLTI);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_a      = i_rs_val;
        w_b      = zext16(w_imm);
        w_wr_reg = w_rt;
        w_wr_en  = 1'b1;
        w_alufun = (w_op == OP_ANDI) ? ALU_AND :
                   (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        w_alufun = ALU_PASSA;
        w_a      = {w_imm, 16'h0000};
        w_wr_reg = w_rt;
        w_wr_en  = 1'b1;
      end
      OP_LW, OP_SW: begin
        w_a      = i_rs_val;
        w_b      = sext16(w_imm);
        w_wr_reg = (w_op == OP_LW) ? w_rt : 5'd0;
        w_wr_en  = (w_op == OP_LW);
      end
      OP_BEQ, OP_BNE: begin
        w_alufun = (w_op == OP_BEQ) ? ALU_EQ : ALU_NEQ;
        w_a      = i_rs_val;
        w_b      = i_rt_val;
      end
      // Compare-with-zero branches treat rs as a signed value.
      OP_BLEZ, OP_BGTZ: begin
        w_alufun = (w_op == OP_BLEZ) ? ALU_LEZ : ALU_GTZ;
        w_a      = i_rs_val;
        w_sign   = 1'b1;
      end
      OP_REGIMM: begin
        if (w_rt == 5'd0) begin
          w_alufun = ALU_LTZ;
          w_a      = i_rs_val;
          w_sign   = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal) begin
      w_alufun = ALU_ADD;
      w_a      = 32'd0;
      w_b      = 32'd0;
      w_sign   = 1'b0;
      w_wr_reg = 5'd0;
      w_wr_en  = 1'b0;
    end
    // $0 is hardwired to zero, so a write to it is dropped.
    if (w_wr_reg == 5'd0) w_wr_en = 1'b0;
  end

  assign o_alufun  = w_alufun;
  assign o_a       = w_a;
  assign o_b       = w_b;
  assign o_sign    = w_sign;
  assign o_wr_reg  = w_wr_reg;
  assign o_wr_en   = w_wr_en;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue register between decode and EX with valid/ready handshake and flush.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer (registered in_ready).
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [5:0]  ex_ALUFun,
  output logic        ex_Sign,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_wr_en,
  output logic        ex_illegal
);

  // Handshake: a transfer happens on an edge where valid && ready on the same
  // side; ex_* hold stable while ex_valid && !ex_ready; flush wins over accept.

  issue_t w_dec;
  logic   w_accept;
  issue_t r_out;
  logic   r_ex_valid;

  alu_issue_decode u_decode (
    .i_instr   (instr),
    .i_rs_val  (rs_val),
    .i_rt_val  (rt_val),
    .o_alufun  (w_dec.alufun),
    .o_a       (w_dec.a),
    .o_b       (w_dec.b),
    .o_sign    (w_dec.sign),
    .o_wr_reg  (w_dec.wr_reg),
    .o_wr_en   (w_dec.wr_en),
    .o_illegal (w_dec.illegal)
  );

  assign w_accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t r_skid;
  logic   r_skid_valid;
  logic   w_out_free;

  assign w_out_free = !r_ex_valid || ex_ready;
  assign in_ready   = !r_skid_valid && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out        <= '0;
      r_ex_valid   <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A held skid entry is older than anything on the input, so it goes first.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_ex_valid   <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out      <= w_dec;
        r_ex_valid <= 1'b1;
      end else begin
        r_ex_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !flush && (!r_ex_valid || ex_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out      <= '0;
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_out      <= w_dec;
      r_ex_valid <= 1'b1;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end
`endif

  assign ex_valid   = r_ex_valid;
  assign ex_A       = r_out.a;
  assign ex_B       = r_out.b;
  assign ex_ALUFun  = r_out.alufun;
  assign ex_Sign    = r_out.sign;
  assign ex_wr_reg  = r_out.wr_reg;
  assign ex_wr_en   = r_out.wr_en;
  assign ex_illegal = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: reset, decode table,
// stall hold, flush and reset-while-stalled.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [5:0]  ex_ALUFun;
  logic        ex_Sign;
  logic [4:0]  ex_wr_reg;
  logic        ex_wr_en;
  logic        ex_illegal;

  int n_total;
  int n_bad;

  alu_issue_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_A       (ex_A),
    .ex_B       (ex_B),
    .ex_ALUFun  (ex_ALUFun),
    .ex_Sign    (ex_Sign),
    .ex_wr_reg  (ex_wr_reg),
    .ex_wr_en   (ex_wr_en),
    .ex_illegal (ex_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [4:0]  wr;
    logic        en;
    logic        ill;
    logic        chk_b;
    logic        chk_s;
    logic        chk_wr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [5:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input logic sign, input logic [4:0] wr,
                         input logic en, input logic ill, input logic chk_b,
                         input logic chk_s, input logic chk_wr);
    vec_t v;
    v.name = name; v.instr = ins; v.rs = rs; v.rt = rt; v.fun = fun; v.a = a; v.b = b;
    v.sign = sign; v.wr = wr; v.en = en; v.ill = ill;
    v.chk_b = chk_b; v.chk_s = chk_s; v.chk_wr = chk_wr;
    vq.push_back(v);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
    flush = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    n_total++; if (ex_A !== 32'd0) begin n_bad++; $display("FAIL reset_A got=%h exp=0", ex_A); end
    n_total++; if (ex_B !== 32'd0) begin n_bad++; $display("FAIL reset_B got=%h exp=0", ex_B); end
    n_total++; if (ex_ALUFun !== 6'd0) begin n_bad++; $display("FAIL reset_fun got=%b exp=0", ex_ALUFun); end
    n_total++; if ({ex_Sign, ex_wr_en, ex_illegal} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {ex_Sign, ex_wr_en, ex_illegal}); end
    n_total++; if (ex_wr_reg !== 5'd0) begin n_bad++; $display("FAIL reset_wr_reg got=%0d exp=0", ex_wr_reg); end
    reset = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_decode();
    add_vec("add",   {6'h00,5'd1,5'd2,5'd3,5'd0,6'h20}, 32'd5, 32'd7,
            6'b000000, 32'd5, 32'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec("sra",   {6'h00,5'd0,5'd5,5'd4,5'd3,6'h03}, 32'h11, 32'h80000000,
            6'b100011, 32'd3, 32'h80000000, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("lui",   {6'h0f,5'd0,5'd6,16'h1234}, 32'h55, 32'h66,
            6'b011010, 32'h12340000, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec("op3f",  {6'h3f,26'd0}, 32'h77, 32'h88,
            6'b000000, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec("addiu0",{6'h09,5'd1,5'd0,16'd1}, 32'd9, 32'd0,
            6'b000000, 32'd9, 32'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("lw",    {6'h23,5'd3,5'd2,16'hfffc}, 32'h100, 32'd0,
            6'b000000, 32'h100, 32'hfffffffc, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec("sw",    {6'h2b,5'd3,5'd2,16'd8}, 32'h200, 32'h1,
            6'b000000, 32'h200, 32'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("beq",   {6'h04,5'd1,5'd2,16'h0010}, 32'd3, 32'd4,
            6'b110011, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("bltz",  {6'h01,5'd1,5'd0,16'h0000}, 32'hffffffff, 32'd4,
            6'b111011, 32'hffffffff, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("andi",  {6'h0c,5'd1,5'd7,16'h8000}, 32'hff, 32'd0,
            6'b011000, 32'hff, 32'h00008000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("slti",  {6'h0a,5'd1,5'd8,16'hffff}, 32'd2, 32'd0,
            6'b110101, 32'd2, 32'hffffffff, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("sllv",  {6'h00,5'd1,5'd2,5'd9,5'd0,6'h04}, 32'd4, 32'h10,
            6'b100000, 32'd4, 32'h10, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("sltu",  {6'h00,5'd1,5'd2,5'd10,5'd0,6'h2b}, 32'd1, 32'd2,
            6'b110101, 32'd1, 32'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec("nor",   {6'h00,5'd1,5'd2,5'd11,5'd0,6'h27}, 32'hf0, 32'h0f,
            6'b010001, 32'hf0, 32'h0f, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("jr_ill",{6'h00,5'd1,5'd0,5'd0,5'd0,6'h08}, 32'd1, 32'd2,
            6'b000000, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    ex_ready = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      in_valid = 1'b1; instr = vq[i].instr; rs_val = vq[i].rs; rt_val = vq[i].rt;
      #1;
      n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready got=%0b exp=1", vq[i].name, in_ready); end
      @(posedge clk); #1;
      n_total++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid got=%0b exp=1", vq[i].name, ex_valid); end
      n_total++; if (ex_ALUFun !== vq[i].fun) begin n_bad++; $display("FAIL %s fun got=%b exp=%b", vq[i].name, ex_ALUFun, vq[i].fun); end
      n_total++; if (ex_A !== vq[i].a) begin n_bad++; $display("FAIL %s A got=%h exp=%h", vq[i].name, ex_A, vq[i].a); end
      if (vq[i].chk_b) begin
        n_total++; if (ex_B !== vq[i].b) begin n_bad++; $display("FAIL %s B got=%h exp=%h", vq[i].name, ex_B, vq[i].b); end
      end
      if (vq[i].chk_s) begin
        n_total++; if (ex_Sign !== vq[i].sign) begin n_bad++; $display("FAIL %s sign got=%0b exp=%0b", vq[i].name, ex_Sign, vq[i].sign); end
      end
      if (vq[i].chk_wr) begin
        n_total++; if (ex_wr_reg !== vq[i].wr) begin n_bad++; $display("FAIL %s wr_reg got=%0d exp=%0d", vq[i].name, ex_wr_reg, vq[i].wr); end
      end
      n_total++; if (ex_wr_en !== vq[i].en) begin n_bad++; $display("FAIL %s wr_en got=%0b exp=%0b", vq[i].name, ex_wr_en, vq[i].en); end
      n_total++; if (ex_illegal !== vq[i].ill) begin n_bad++; $display("FAIL %s illegal got=%0b exp=%0b", vq[i].name, ex_illegal, vq[i].ill); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL decode_drain valid got=%0b exp=0", ex_valid); end
  endtask

  task automatic test_stall();
    logic exp_rdy_open;
    logic exp_rdy_release;
`ifdef ALU_ISSUE_SKID_EN
    exp_rdy_open = 1'b1; exp_rdy_release = 1'b0;
`else
    exp_rdy_open = 1'b0; exp_rdy_release = 1'b1;
`endif
    ex_ready = 1'b0;
    in_valid = 1'b1; instr = {6'h00,5'd1,5'd2,5'd3,5'd0,6'h21}; rs_val = 32'd11; rt_val = 32'd22;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b1 || ex_A !== 32'd11) begin n_bad++; $display("FAIL stall_first valid=%0b A=%h exp 1/0000000b", ex_valid, ex_A); end
    n_total++; if (in_ready !== exp_rdy_open) begin n_bad++; $display("FAIL stall_in_ready_open got=%0b exp=%0b", in_ready, exp_rdy_open); end
    instr = {6'h00,5'd1,5'd2,5'd5,5'd0,6'h23}; rs_val = 32'd33; rt_val = 32'd44;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d valid got=%0b exp=1", k, ex_valid); end
      n_total++; if (ex_A !== 32'd11 || ex_B !== 32'd22) begin n_bad++; $display("FAIL stall_hold%0d A=%h B=%h exp 0b/16", k, ex_A, ex_B); end
      n_total++; if (ex_ALUFun !== 6'b000000 || ex_wr_reg !== 5'd3) begin n_bad++; $display("FAIL stall_hold%0d fun=%b wr=%0d exp 000000/3", k, ex_ALUFun, ex_wr_reg); end
      n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d in_ready got=%0b exp=0", k, in_ready); end
`ifdef ALU_ISSUE_SKID_EN
      if (k == 0) in_valid = 1'b0;
`endif
    end
    ex_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== exp_rdy_release) begin n_bad++; $display("FAIL stall_release in_ready got=%0b exp=%0b", in_ready, exp_rdy_release); end
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b1 || ex_A !== 32'd33 || ex_ALUFun !== 6'b000001 || ex_wr_reg !== 5'd5) begin
      n_bad++; $display("FAIL stall_second valid=%0b A=%h fun=%b wr=%0d exp 1/21/000001/5", ex_valid, ex_A, ex_ALUFun, ex_wr_reg);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain valid got=%0b exp=0", ex_valid); end
  endtask

  task automatic test_flush();
    ex_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; instr = {6'h00,5'd1,5'd2,5'd3,5'd0,6'h20}; rs_val = 32'd1; rt_val = 32'd2;
    #1;
    n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept valid got=%0b exp=0", ex_valid); end
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_issue valid got=%0b exp=0", ex_valid); end
    ex_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_held valid got=%0b exp=0", ex_valid); end
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_reset_stall();
    ex_ready = 1'b0; in_valid = 1'b1;
    instr = {6'h00,5'd1,5'd2,5'd3,5'd0,6'h20}; rs_val = 32'd5; rt_val = 32'd7;
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL rst_stall_pre valid got=%0b exp=1", ex_valid); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_total++; if (ex_valid !== 1'b0 || ex_A !== 32'd0 || ex_B !== 32'd0 || ex_Sign !== 1'b0 || ex_wr_reg !== 5'd0 || ex_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_stall_now valid=%0b A=%h B=%h sign=%0b wr=%0d en=%0b exp all 0", ex_valid, ex_A, ex_B, ex_Sign, ex_wr_reg, ex_wr_en);
    end
    #1;
    reset = 1'b1;
    ex_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_discard valid got=%0b exp=0", ex_valid); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
